mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
//  Memory-stage load/store unit. Consumes the ex/mem register outputs (mem_aluop, mem_addr, mem_reg2,
//  mem_wd/wreg/wdata) and performs data-bus transactions over a req/ack handshake.
//  Passes non-memory results through to mem/wb and holds the pipeline via stallreq until each access completes.
// PARAMETERS
//  OP_BASE      8'h20  aluop of LB; OP_BASE+1..+7 = LBU, LH, LHU, LW, SB, SH, SW
//  ACK_TIMEOUT  16     max cycles in REQ waiting for dbus_ack before abort (>=2)
// PORTS
//  clk          in   1   clock
//  rst          in   1   async reset, active-low
//  mem_aluop    in   8   operation from ex/mem
//  mem_addr     in   32  effective byte address
//  mem_reg2     in   32  store data (low byte/half used for SB/SH)
//  mem_wd       in   5   destination register
//  mem_wreg     in   1   destination write enable
//  mem_wdata    in   32  ALU result (non-memory ops)
//  wb_wd        out  5   to mem/wb: destination register
//  wb_wreg      out  1   to mem/wb: write enable
//  wb_wdata     out  32  to mem/wb: write data
//  stallreq     out  1   stall request to pipeline control
//  dbus_req     out  1   bus request, held until ack/abort
//  dbus_we      out  1   1 = store
//  dbus_addr    out  32  word-aligned address ({addr[31:2],2'b00})
//  dbus_sel     out  4   byte lane enables, little-endian, lane = addr[1:0]
//  dbus_wdata   out  32  store data replicated to all lanes
//  dbus_rdata   in   32  read data, valid with dbus_ack
//  dbus_ack     in   1   transfer complete (ignored outside REQ)
//  bus_err      out  1   one-cycle pulse on ack timeout
// BEHAVIOUR
//  Reset: state IDLE, timer 0, dbus_req/we/addr/sel/wdata=0, ld_data=0, bus_err=0; comb outputs follow.
//  memop = mem_aluop in OP_BASE..OP_BASE+7. Non-memop: wb_* = mem_* combinationally, stallreq=0.
//  FSM IDLE/REQ/DONE:
//   IDLE: memop -> stallreq=1; register bus fields, dbus_req<=1, timer<=0, goto REQ; wb_wreg=0.
//   REQ: stallreq=1, wb_wreg=0. dbus_ack -> dbus_req<=0, ld_data<=extended lane data, goto DONE.
//        else timer==ACK_TIMEOUT-1 -> dbus_req<=0, bus_err<=1, ld_data<=0, goto DONE; else timer++.
//   DONE: stallreq=0; loads: wb_wdata=ld_data, wb_wreg=mem_wreg; stores: wb_wreg=0. bus_err<=0. goto IDLE.
//  Min memop occupancy 3 cycles (ack in first REQ cycle); ACK_TIMEOUT+2 worst case.
//  Stores: SB sel=0001<<addr[1:0], wdata={4{reg2[7:0]}}; SH sel=0011/1100 by addr[1], {2{reg2[15:0]}};
//   SW sel=1111, reg2. Loads use same sel, dbus_we=0.
//  Load extend: LB/LH sign-extend, LBU/LHU zero-extend selected lane(s); LW full word.
//  ack arriving same edge as timeout: ack wins, no bus_err.
//  Async reset mid-REQ: dbus_req drops immediately, no writeback, state IDLE.
//  Bus fields stable while dbus_req=1; mem_* inputs held stable by stall during REQ.
// CONFIGURATION
//  LSU_MISALIGN_EXC_EN defined: LH/LHU/SH with addr[0]!=0, or LW/SW with addr[1:0]!=0 -> no bus
//   request; IDLE goes straight to DONE, misalign_exc (extra out, 1 bit) pulses 1 cycle in DONE,
//   wb_wreg=0. Reset value 0.
//  Undefined: port absent; low address bits ignored (half uses addr[1] only, word ignores addr[1:0]).
// TESTING
//  LW addr 0x100, ack 1 cycle after req, rdata 0xDEADBEEF -> stallreq 2 cycles, wb_wdata 0xDEADBEEF, wb_wreg=1.
//  LB addr 0x103, rdata 0x80xxxxxx -> sel 1000, wb_wdata 0xFFFFFF80; LBU same -> 0x00000080.
//  SH addr 0x202, reg2 0x1234ABCD -> dbus_we=1, sel 1100, wdata 0xABCDABCD, wb_wreg=0.
//  LW with no ack, ACK_TIMEOUT=16 -> req drops after 16 REQ cycles, bus_err pulse, wb_wreg=0.
//  LW addr 0x101 with LSU_MISALIGN_EXC_EN -> no dbus_req, misalign_exc pulse, stallreq 1 cycle.
//  rst low mid-REQ -> dbus_req=0 same cycle; after release, ADD passes wb_wdata=mem_wdata, stallreq=0.

Source files
------------

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: drives a req/ack data bus and stalls until each access ends.
// Optional build macro LSU_MISALIGN_EXC_EN adds misalign_exc and blocks unaligned half/word accesses.
module mem_lsu #(
    parameter logic [7:0] OP_BASE     = 8'h20,
    parameter int         ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_reg2,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        stallreq,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_sel,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
`ifdef LSU_MISALIGN_EXC_EN
    output logic        misalign_exc,
`endif
    output logic        bus_err
);

    localparam int TW = $clog2(ACK_TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [7:0] OP_LAST = OP_BASE + 8'd7;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t state;
    logic [TW-1:0] timer;
    logic [31:0] ld_data;

    logic memop;
    logic [2:0] op;
    logic is_store;
    logic is_byte;
    logic is_half;
    logic is_word;
    logic [3:0] sel_n;
    logic [31:0] wdata_n;
    logic [7:0] lane_b;
    logic [15:0] lane_h;
    logic [31:0] ld_ext;

    // op is the offset from OP_BASE; only the low three bits matter
    assign memop = (mem_aluop >= OP_BASE) && (mem_aluop <= OP_LAST);
    assign op = mem_aluop[2:0] - OP_BASE[2:0];
    assign is_store = (op > 3'd4);
    assign is_byte = (op == 3'd0) || (op == 3'd1) || (op == 3'd5);
    assign is_half = (op == 3'd2) || (op == 3'd3) || (op == 3'd6);
    assign is_word = (op == 3'd4) || (op == 3'd7);

`ifdef LSU_MISALIGN_EXC_EN
    logic misal;
    assign misal = (is_half && mem_addr[0]) ||
                   (is_word && (mem_addr[1:0] != 2'b00));
`endif

    // Lane enables and lane-replicated store data for the access size
    always_comb begin
        sel_n = 4'b1111;
        wdata_n = mem_reg2;
        unique case (1'b1)
            is_byte: begin
                sel_n = 4'b0001 << mem_addr[1:0];
                wdata_n = {4{mem_reg2[7:0]}};
            end
            is_half: begin
                sel_n = mem_addr[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{mem_reg2[15:0]}};
            end
            default: begin
                sel_n = 4'b1111;
                wdata_n = mem_reg2;
            end
        endcase
    end

    // Pick the addressed lane(s) of read data and extend to 32 bits
    always_comb begin
        lane_b = dbus_rdata[{mem_addr[1:0], 3'b000} +: 8];
        lane_h = mem_addr[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        case (op)
            3'd0: ld_ext = {{24{lane_b[7]}}, lane_b};
            3'd1: ld_ext = {24'b0, lane_b};
            3'd2: ld_ext = {{16{lane_h[15]}}, lane_h};
            3'd3: ld_ext = {16'b0, lane_h};
            default: ld_ext = dbus_rdata;
        endcase
    end

    // Access sequencer: issue, wait for ack or timeout, then one writeback cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            timer <= '0;
            dbus_req <= 1'b0;
            dbus_we <= 1'b0;
            dbus_addr <= 32'b0;
            dbus_sel <= 4'b0;
            dbus_wdata <= 32'b0;
            ld_data <= 32'b0;
            bus_err <= 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
            misalign_exc <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    bus_err <= 1'b0;
                    if (memop) begin
                        ld_data <= 32'b0;
`ifdef LSU_MISALIGN_EXC_EN
                        if (misal) begin
                            misalign_exc <= 1'b1;
                            state <= DONE;
                        end else
`endif
                        begin
                            dbus_req <= 1'b1;
                            dbus_we <= is_store;
                            dbus_addr <= {mem_addr[31:2], 2'b00};
                            dbus_sel <= sel_n;
                            dbus_wdata <= wdata_n;
                            timer <= '0;
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dbus_ack) begin
                        dbus_req <= 1'b0;
                        ld_data <= ld_ext;
                        state <= DONE;
                    end else if (timer == T_LAST) begin
                        dbus_req <= 1'b0;
                        bus_err <= 1'b1;
                        ld_data <= 32'b0;
                        state <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE: begin
                    bus_err <= 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
                    misalign_exc <= 1'b0;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wb_wd = mem_wd;

    // Writeback and stall: pass-through unless a memory access is in flight
    always_comb begin
        wb_wreg = mem_wreg;
        wb_wdata = mem_wdata;
        stallreq = 1'b0;
        unique case (state)
            IDLE: begin
                if (memop) begin
                    stallreq = 1'b1;
                    wb_wreg = 1'b0;
                end
            end
            REQ: begin
                stallreq = 1'b1;
                wb_wreg = 1'b0;
            end
            DONE: begin
                if (is_store) begin
                    wb_wreg = 1'b0;
                end else begin
                    wb_wdata = ld_data;
`ifdef LSU_MISALIGN_EXC_EN
                    wb_wreg = mem_wreg && !bus_err && !misalign_exc;
`else
                    wb_wreg = mem_wreg && !bus_err;
`endif
                end
            end
            default: begin
                stallreq = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: fixed vectors, hand sequences for reset and timeout,
// and random operations against a byte-lane reference model.
module tb_mem_lsu;

    localparam logic [7:0] OP_BASE = 8'h20;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_addr;
    logic [31:0] mem_reg2;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        stallreq;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;
    logic        bus_err;
`ifdef LSU_MISALIGN_EXC_EN
    logic        misalign_exc;
`endif

    mem_lsu #(.OP_BASE(OP_BASE), .ACK_TIMEOUT(T)) dut (
        .clk(clk),
        .rst(rst),
        .mem_aluop(mem_aluop),
        .mem_addr(mem_addr),
        .mem_reg2(mem_reg2),
        .mem_wd(mem_wd),
        .mem_wreg(mem_wreg),
        .mem_wdata(mem_wdata),
        .wb_wd(wb_wd),
        .wb_wreg(wb_wreg),
        .wb_wdata(wb_wdata),
        .stallreq(stallreq),
        .dbus_req(dbus_req),
        .dbus_we(dbus_we),
        .dbus_addr(dbus_addr),
        .dbus_sel(dbus_sel),
        .dbus_wdata(dbus_wdata),
        .dbus_rdata(dbus_rdata),
        .dbus_ack(dbus_ack),
`ifdef LSU_MISALIGN_EXC_EN
        .misalign_exc(misalign_exc),
`endif
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] rdata;
        logic [31:0] wdat;
        int          delay;
        logic        wreg;
        int          exp_stall;
        logic [3:0]  exp_sel;
        logic        exp_we;
        logic [31:0] exp_bw;
        logic [31:0] exp_wb;
        logic        exp_wreg;
        logic        exp_err;
        logic        exp_mx;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [7:0] op, input logic [31:0] addr, reg2, rdata, wdat,
        input int delay, input logic wreg, input int stall,
        input logic [3:0] sel, input logic we, input logic [31:0] bw, wb,
        input logic wrg, input logic err);
        vec_t v;
        v.op = op; v.addr = addr; v.reg2 = reg2; v.rdata = rdata;
        v.wdat = wdat; v.delay = delay; v.wreg = wreg;
        v.exp_stall = stall; v.exp_sel = sel; v.exp_we = we;
        v.exp_bw = bw; v.exp_wb = wb; v.exp_wreg = wrg;
        v.exp_err = err; v.exp_mx = 1'b0;
        return v;
    endfunction

    // Reference: treat the bus word as four bytes and the access as n bytes at an offset
    task automatic ref_model(inout vec_t v);
        int k, n, off;
        longint mask, x, acc;
        logic mis, tmo;
        k = int'(v.op) - int'(OP_BASE);
        v.exp_mx = 1'b0;
        if (k < 0 || k > 7) begin
            v.exp_stall = 0; v.exp_wb = v.wdat; v.exp_wreg = v.wreg;
            v.exp_err = 1'b0; v.exp_sel = 4'h0; v.exp_we = 1'b0;
            v.exp_bw = 32'h0;
            return;
        end
        n = (k == 4 || k == 7) ? 4 : (k == 2 || k == 3 || k == 6) ? 2 : 1;
        off = (n == 4) ? 0 : (int'(v.addr % 4) / n) * n;
        v.exp_sel = 4'(((1 << n) - 1) << off);
        v.exp_we = (k >= 5);
        mask = (64'd1 << (8 * n)) - 1;
        x = longint'(v.reg2) & mask;
        acc = 0;
        for (int i = 0; i < 4 / n; i++) acc = acc | (x << (8 * n * i));
        v.exp_bw = 32'(acc);
        x = (longint'(v.rdata) >> (8 * off)) & mask;
        if ((k == 0 || k == 2) && x >= (64'd1 << (8 * n - 1)))
            x = x - (64'd1 << (8 * n));
        v.exp_wb = 32'(x);
        mis = 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
        mis = (v.addr % n) != 0;
`endif
        tmo = !mis && (v.delay >= T);
        v.exp_stall = mis ? 1 : 1 + (tmo ? T : v.delay + 1);
        v.exp_err = tmo;
        v.exp_mx = mis;
        v.exp_wreg = (k < 5 && !tmo && !mis) ? v.wreg : 1'b0;
        if (tmo || mis) v.exp_wb = 32'h0;
    endtask

    // Drive one operation, act as bus slave, then compare everything observed
    task automatic check_op(input string tag, input vec_t v);
        int stall, rq, k;
        logic done, saw_req, stable;
        logic [3:0] sel;
        logic we, err, mx, wbw, req_done, err2, req2;
        logic [31:0] baddr, bw, wbd;
        logic [4:0] wd, wdo;
        logic memop_v, load_v;
        stall = 0; rq = 0; done = 1'b0; saw_req = 1'b0; stable = 1'b1;
        sel = 4'h0; we = 1'b0; baddr = 32'h0; bw = 32'h0;
        wbd = 32'h0; wbw = 1'b0; err = 1'b0; mx = 1'b0; req_done = 1'b0;
        wdo = 5'h0;
        wd = 5'($urandom);
        @(negedge clk);
        mem_aluop = v.op; mem_addr = v.addr; mem_reg2 = v.reg2;
        mem_wdata = v.wdat; mem_wreg = v.wreg; mem_wd = wd;
        dbus_ack = 1'b0; dbus_rdata = $urandom;
        for (int c = 0; c < 60 && !done; c++) begin
            if (c > 0) begin
                @(negedge clk);
                dbus_ack = 1'b0;
                dbus_rdata = $urandom;
            end
            #1;
            if (!stallreq) begin
                done = 1'b1;
                wbd = wb_wdata; wbw = wb_wreg; wdo = wb_wd;
                err = bus_err; req_done = dbus_req;
`ifdef LSU_MISALIGN_EXC_EN
                mx = misalign_exc;
`endif
            end else begin
                stall++;
                if (dbus_req) begin
                    if (!saw_req) begin
                        sel = dbus_sel; we = dbus_we;
                        baddr = dbus_addr; bw = dbus_wdata;
                    end else if (sel !== dbus_sel || we !== dbus_we ||
                                 baddr !== dbus_addr || bw !== dbus_wdata) begin
                        stable = 1'b0;
                    end
                    saw_req = 1'b1;
                    if (rq == v.delay) begin
                        dbus_ack = 1'b1;
                        dbus_rdata = v.rdata;
                    end
                    rq++;
                end
            end
        end
        chk({tag, ".finished"}, 32'(done), 32'h1);
        @(negedge clk);
        mem_aluop = 8'h00;
        dbus_ack = 1'b0;
        #1;
        err2 = bus_err; req2 = dbus_req;
        k = int'(v.op) - int'(OP_BASE);
        memop_v = (k >= 0 && k <= 7);
        load_v = memop_v && k < 5;
        chk({tag, ".stall"}, 32'(stall), 32'(v.exp_stall));
        chk({tag, ".wb_wreg"}, 32'(wbw), 32'(v.exp_wreg));
        chk({tag, ".wb_wd"}, 32'(wdo), 32'(wd));
        chk({tag, ".bus_err"}, 32'(err), 32'(v.exp_err));
        chk({tag, ".err_pulse"}, 32'(err2), 32'h0);
        chk({tag, ".req_idle"}, 32'(req_done | req2), 32'h0);
        if (!memop_v || load_v)
            chk({tag, ".wb_wdata"}, wbd, v.exp_wb);
        if (memop_v && !v.exp_mx) begin
            chk({tag, ".sel"}, 32'(sel), 32'(v.exp_sel));
            chk({tag, ".we"}, 32'(we), 32'(v.exp_we));
            chk({tag, ".addr"}, baddr, v.addr & 32'hFFFF_FFFC);
            chk({tag, ".stable"}, 32'(stable), 32'h1);
            if (v.exp_we) chk({tag, ".wdata"}, bw, v.exp_bw);
        end else begin
            chk({tag, ".no_req"}, 32'(saw_req), 32'h0);
        end
`ifdef LSU_MISALIGN_EXC_EN
        chk({tag, ".misalign"}, 32'(mx), 32'(v.exp_mx));
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[12];
        vec_t v;
        int r;
        logic got;

        tbl[0]  = mk(8'h24, 32'h100, 32'h0, 32'hDEADBEEF, 32'h1111, 0, 1'b1,
                     2, 4'hF, 1'b0, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0);
        tbl[1]  = mk(8'h20, 32'h103, 32'h0, 32'h80123456, 32'h2222, 0, 1'b1,
                     2, 4'h8, 1'b0, 32'h0, 32'hFFFFFF80, 1'b1, 1'b0);
        tbl[2]  = mk(8'h21, 32'h103, 32'h0, 32'h80123456, 32'h3333, 0, 1'b0,
                     2, 4'h8, 1'b0, 32'h0, 32'h00000080, 1'b0, 1'b0);
        tbl[3]  = mk(8'h26, 32'h202, 32'h1234ABCD, 32'h0, 32'h4444, 0, 1'b1,
                     2, 4'hC, 1'b1, 32'hABCDABCD, 32'h0, 1'b0, 1'b0);
        tbl[4]  = mk(8'h22, 32'h102, 32'h0, 32'h80017FFF, 32'h5555, 2, 1'b1,
                     4, 4'hC, 1'b0, 32'h0, 32'hFFFF8001, 1'b1, 1'b0);
        tbl[5]  = mk(8'h23, 32'h100, 32'h0, 32'h8001F00F, 32'h6666, 1, 1'b1,
                     3, 4'h3, 1'b0, 32'h0, 32'h0000F00F, 1'b1, 1'b0);
        tbl[6]  = mk(8'h25, 32'h301, 32'h000000A5, 32'h0, 32'h7777, 0, 1'b1,
                     2, 4'h2, 1'b1, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0);
        tbl[7]  = mk(8'h27, 32'h400, 32'hCAFEF00D, 32'h0, 32'h8888, 3, 1'b1,
                     5, 4'hF, 1'b1, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
        tbl[8]  = mk(8'h24, 32'h104, 32'h0, 32'h12345678, 32'h9999, T - 1, 1'b1,
                     T + 1, 4'hF, 1'b0, 32'h0, 32'h12345678, 1'b1, 1'b0);
        tbl[9]  = mk(8'h24, 32'h108, 32'h0, 32'h12345678, 32'hAAAA, 99, 1'b1,
                     T + 1, 4'hF, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tbl[10] = mk(8'h01, 32'h0, 32'h0, 32'h0, 32'h000000AB, 0, 1'b1,
                     0, 4'h0, 1'b0, 32'h0, 32'h000000AB, 1'b1, 1'b0);
        tbl[11] = mk(8'h20, 32'h101, 32'h0, 32'h00007F00, 32'hBBBB, 0, 1'b1,
                     2, 4'h2, 1'b0, 32'h0, 32'h0000007F, 1'b1, 1'b0);

        rst = 1'b0;
        mem_aluop = 8'h00; mem_addr = 32'h0; mem_reg2 = 32'h0;
        mem_wd = 5'd3; mem_wreg = 1'b1; mem_wdata = 32'h13572468;
        dbus_rdata = 32'h0; dbus_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset.req", 32'(dbus_req), 32'h0);
        chk("reset.we", 32'(dbus_we), 32'h0);
        chk("reset.addr", dbus_addr, 32'h0);
        chk("reset.sel", 32'(dbus_sel), 32'h0);
        chk("reset.wdata", dbus_wdata, 32'h0);
        chk("reset.bus_err", 32'(bus_err), 32'h0);
        chk("reset.stall", 32'(stallreq), 32'h0);
        chk("reset.wb_wdata", wb_wdata, 32'h13572468);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++)
            check_op($sformatf("vec%0d", i), tbl[i]);

`ifdef LSU_MISALIGN_EXC_EN
        v = mk(8'h24, 32'h101, 32'h0, 32'h0, 32'hCCCC, 0, 1'b1,
               1, 4'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        v.exp_mx = 1'b1;
        check_op("misalign_lw", v);
`endif

        // async reset in the middle of a request
        @(negedge clk);
        mem_aluop = 8'h24; mem_addr = 32'h500; mem_wreg = 1'b1;
        dbus_ack = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            #1;
            got = dbus_req;
        end
        chk("rstmid.req_seen", 32'(got), 32'h1);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rstmid.req_drop", 32'(dbus_req), 32'h0);
        chk("rstmid.no_wb", 32'(wb_wreg), 32'h0);
        @(negedge clk);
        mem_aluop = 8'h01; mem_wdata = 32'h0BADF00D; mem_wreg = 1'b1;
        rst = 1'b1;
        #1;
        chk("rstmid.add_wdata", wb_wdata, 32'h0BADF00D);
        chk("rstmid.add_wreg", 32'(wb_wreg), 32'h1);
        chk("rstmid.add_stall", 32'(stallreq), 32'h0);
        @(negedge clk);
        #1;
        chk("rstmid.idle_req", 32'(dbus_req), 32'h0);
        chk("rstmid.idle_err", 32'(bus_err), 32'h0);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0)
                v.op = 8'($urandom_range(0, 31));
            else
                v.op = OP_BASE + 8'($urandom_range(0, 7));
            v.addr = $urandom;
            v.reg2 = $urandom;
            v.rdata = $urandom;
            v.wdat = $urandom;
            v.wreg = 1'($urandom);
            r = $urandom_range(0, 9);
            v.delay = (r < 7) ? $urandom_range(0, 3) :
                      (r == 7) ? T - 1 : (r == 8) ? T : 20;
            ref_model(v);
            check_op($sformatf("rnd%0d", i), v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
